glb_sram_cfg_arbiter: RTL and testbench
=======================================

Name: glb_sram_cfg_arbiter

Overview:
- Shares the single west-edge SRAM configuration chain of the global buffer between NUM_REQ requesters (requester 0 = JTAG/config controller, requester 1 = processor/host slave).
- Grants one transaction at a time using round-robin arbitration.
- Issues single-cycle write/read pulses onto the chain and tracks the one outstanding read until its rd_data_valid returns or a timeout expires.
- Routes the read response back to the requester that owns it.

Parameters:
- NUM_REQ, 2, number of requesters (>=2)
- ADDR_WIDTH, 22, SRAM config address width (tile sel + bank sel + bank addr)
- DATA_WIDTH, 32, config data width (CGRA_CFG_DATA_WIDTH)
- RD_TIMEOUT, 64, cycles to wait for read data before returning an error (>=4)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (combinational, IDLE only)
- req_wr  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- resp_valid  out  NUM_REQ  one-cycle read-response pulse to the owning requester
- resp_data  out  DATA_WIDTH  read data, shared by all requesters
- resp_err  out  1  qualifies resp_valid; 1 means timeout
- sram_cfg_wr_en  out  1  chain write pulse
- sram_cfg_wr_addr  out  ADDR_WIDTH  chain write address
- sram_cfg_wr_data  out  DATA_WIDTH  chain write data
- sram_cfg_rd_en  out  1  chain read pulse
- sram_cfg_rd_addr  out  ADDR_WIDTH  chain read address
- sram_cfg_rd_data  in  DATA_WIDTH  chain return data
- sram_cfg_rd_data_valid  in  1  chain return valid
- stray_rd_err  out  1  sticky flag: rd_data_valid arrived while not in WAIT_RD
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 0, timeout counter 0, stray_rd_err 0. Reset asserted mid-transaction aborts it with no response pulse.
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - Grant g is the first requester with req_valid=1, searching from the pointer upward with wrap.
  - req_ready[g]=1 in that cycle (cycle T); all other req_ready bits stay 0.
  - On the handshake, capture wr/addr/wdata/owner and go to ISSUE. Pointer becomes (g+1) mod NUM_REQ.
  - req_ready is 0 in every non-IDLE state.
- ISSUE (cycle T+1):
  - Write: sram_cfg_wr_en=1 with wr_addr/wr_data for exactly one cycle; rd_en=0. Next state is IDLE, so the next grant can occur at T+2. Writes produce no response.
  - Read: sram_cfg_rd_en=1 with rd_addr for exactly one cycle. Next state WAIT_RD, timeout counter cleared to 0.
  - Address and data outputs are registered and hold their last value when the enables are low.
- WAIT_RD:
  - The counter increments every cycle.
  - If sram_cfg_rd_data_valid=1: capture rd_data, resp_err=0, go to RESP.
  - Else if counter == RD_TIMEOUT-1: data=0, resp_err=1, go to RESP.
  - Valid and timeout in the same cycle: valid wins.
- RESP: resp_valid[owner]=1 for exactly one cycle with resp_data/resp_err; then IDLE.
- Latency: a read returning rd_data_valid at cycle V (V >= T+2) produces resp_valid at V+1.
- resp_data and resp_err hold until the next response.
- Stray returns: sram_cfg_rd_data_valid=1 in IDLE, ISSUE or RESP is ignored for data and sets stray_rd_err; only reset clears it.
- A requester must hold valid/wr/addr/wdata stable until ready. Dropping valid before grant is legal and forfeits the request.
- Exactly one transaction is outstanding at a time; there is no pipelining of reads behind writes.

Decomposition:
- Shared package global_buffer_pkg: state typedef enum (IDLE, ISSUE, WAIT_RD, RESP) and default constants for RD_TIMEOUT and the stray-flag policy.
- Address/data widths come from global_buffer_param.
- One sub-module, glb_rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: req vector, enable, advance.
  - Outputs: one-hot grant and grant index.
  - Holds the pointer register.

Test Plan:
- Single write: req0 wr, addr 0x00_1004, data 0xDEADBEEF -> ready0 at T; wr_en=1 at T+1 with that addr/data; no resp_valid; busy low at T+2.
- Single read: req1 rd, addr 0x04_0010; bench returns valid with 0x12345678 six cycles after rd_en -> resp_valid[1]=1 one cycle later, data 0x12345678, resp_err=0, resp_valid[0]=0.
- Fairness: both requesters continuously valid with writes -> grants alternate 0,1,0,1; pointer wraps; no requester is granted twice in a row.
- Timeout: a read with no return -> resp_valid[owner] exactly RD_TIMEOUT+1 cycles after the rd_en cycle, data 0, resp_err=1. A late rd_data_valid afterwards sets stray_rd_err.
- Boundary: valid arrives in the same cycle the counter reaches RD_TIMEOUT-1 -> data returned, resp_err=0.
- Reset mid-read: assert reset_n=0 during WAIT_RD -> all outputs 0 immediately. After release: IDLE, pointer 0, no response pulse; a new read completes normally.

Source files
------------

// File: rtl/glb_sram_cfg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : global_buffer_pkg
// Brief   : Shared types and defaults for the global-buffer SRAM config path.
// Rev     : 1.0  initial release
// ============================================================================
package global_buffer_pkg;

  // Geometry of the west-edge SRAM configuration chain
  localparam int GLB_ADDR_WIDTH = 22;
  localparam int GLB_DATA_WIDTH = 32;

  localparam int RD_TIMEOUT_DEFAULT = 64;
  localparam bit STRAY_FLAG_EN      = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } cfg_arb_state_t;

endpackage : global_buffer_pkg
`default_nettype wire

// File: rtl/glb_sram_cfg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : glb_sram_cfg_arbiter_if
// Brief     : Requester handshake plus SRAM config chain signals.
// Rev       : 1.0  initial release
// ============================================================================
interface glb_sram_cfg_arbiter_if
  import global_buffer_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = GLB_ADDR_WIDTH,
  parameter int DATA_WIDTH = GLB_DATA_WIDTH
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          resp_err;

  logic                          sram_cfg_wr_en;
  logic [ADDR_WIDTH-1:0]         sram_cfg_wr_addr;
  logic [DATA_WIDTH-1:0]         sram_cfg_wr_data;
  logic                          sram_cfg_rd_en;
  logic [ADDR_WIDTH-1:0]         sram_cfg_rd_addr;
  logic [DATA_WIDTH-1:0]         sram_cfg_rd_data;
  logic                          sram_cfg_rd_data_valid;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  sram_cfg_rd_data, sram_cfg_rd_data_valid,
    output req_ready, resp_valid, resp_data, resp_err,
    output sram_cfg_wr_en, sram_cfg_wr_addr, sram_cfg_wr_data,
    output sram_cfg_rd_en, sram_cfg_rd_addr
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    output sram_cfg_rd_data, sram_cfg_rd_data_valid,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  sram_cfg_wr_en, sram_cfg_wr_addr, sram_cfg_wr_data,
    input  sram_cfg_rd_en, sram_cfg_rd_addr
  );

endinterface : glb_sram_cfg_arbiter_if
`default_nettype wire

// File: rtl/glb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : glb_rr_arbiter
// Brief  : Round-robin grant with a pointer that moves past each winner.
// Rev    : 1.0  initial release
// ============================================================================
module glb_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  wire logic                       clk,
  input  wire logic                       reset_n,
  input  wire logic [NUM_REQ-1:0]         req,
  input  wire logic                       enable,
  input  wire logic                       advance,
  output logic      [NUM_REQ-1:0]         grant,
  output logic      [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  // Search starts at the pointer and wraps, so the last winner has lowest priority
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (enable && !w_found && req[(int'(r_ptr) + k) % NUM_REQ]) begin
        grant[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
        grant_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule : glb_rr_arbiter
`default_nettype wire

// File: rtl/glb_sram_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module : glb_sram_cfg_arbiter
// Brief  : Shares the SRAM config chain between requesters, one transaction
//          at a time, with read-return tracking and timeout.
// Rev    : 1.0  initial release
// ============================================================================
module glb_sram_cfg_arbiter
  import global_buffer_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = GLB_ADDR_WIDTH,
  parameter int DATA_WIDTH = GLB_DATA_WIDTH,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEFAULT
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  glb_sram_cfg_arbiter_if.slave   bus,
  output logic                    stray_rd_err,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_TIMEOUT);

  cfg_arb_state_t        r_state, w_next;
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_grant_idx;
  logic [IDX_W-1:0]      r_owner;
  logic                  w_take;
  logic                  r_wr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_rd_hit;
  logic                  w_timeout;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_err;
  logic                  r_stray;

  glb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (bus.req_valid),
    .enable    (r_state == IDLE),
    .advance   (w_take),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_take        = |w_grant;
  assign bus.req_ready = w_grant;
  assign w_rd_hit      = (r_state == WAIT_RD) && bus.sram_cfg_rd_data_valid;
  assign w_timeout     = (r_state == WAIT_RD) && !bus.sram_cfg_rd_data_valid &&
                         (r_cnt == CNT_W'(RD_TIMEOUT - 1));

  assign bus.sram_cfg_wr_addr = r_wr_addr;
  assign bus.sram_cfg_wr_data = r_wr_data;
  assign bus.sram_cfg_rd_addr = r_rd_addr;
  assign bus.resp_data        = r_resp_data;
  assign bus.resp_err         = r_resp_err;
  assign stray_rd_err         = r_stray;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    bus.sram_cfg_wr_en = 1'b0;
    bus.sram_cfg_rd_en = 1'b0;
    bus.resp_valid     = '0;
    busy               = (r_state != IDLE);
    case (r_state)
      IDLE:    if (w_take) w_next = ISSUE;
      ISSUE: begin
        bus.sram_cfg_wr_en = r_wr;
        bus.sram_cfg_rd_en = !r_wr;
        w_next             = r_wr ? IDLE : WAIT_RD;
      end
      WAIT_RD: if (w_rd_hit || w_timeout) w_next = RESP;
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          bus.resp_valid[i] = (r_owner == IDX_W'(i));
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= '0;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_addr   <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      // Only the address bus of the chosen direction changes, the other holds
      if (w_take) begin
        r_owner <= w_grant_idx;
        r_wr    <= bus.req_wr[w_grant_idx];
        if (bus.req_wr[w_grant_idx]) begin
          r_wr_addr <= bus.req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          r_wr_data <= bus.req_wdata[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          r_rd_addr <= bus.req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
      if (r_state == ISSUE)        r_cnt <= '0;
      else if (r_state == WAIT_RD) r_cnt <= r_cnt + 1'b1;
      if (w_rd_hit) begin
        r_resp_data <= bus.sram_cfg_rd_data;
        r_resp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b1;
      end
      if (STRAY_FLAG_EN && bus.sram_cfg_rd_data_valid && (r_state != WAIT_RD)) begin
        r_stray <= 1'b1;
      end
    end
  end

endmodule : glb_sram_cfg_arbiter
`default_nettype wire

// File: tb/tb_glb_sram_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_glb_sram_cfg_arbiter
// Brief  : Self-checking bench for the SRAM config chain arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_glb_sram_cfg_arbiter;

  localparam int NR = 2;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    logic          err;
  } resp_exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic stray_rd_err;
  logic busy;

  int n_cmp = 0;
  int n_err = 0;

  wr_exp_t   wq[$];
  resp_exp_t rq[$];

  glb_sram_cfg_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  glb_sram_cfg_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .stray_rd_err (stray_rd_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.sram_cfg_wr_en, bus.sram_cfg_rd_en, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ready=%b resp=%b wr=%b rd=%b busy=%b, expected all 0",
               bus.req_ready, bus.resp_valid, bus.sram_cfg_wr_en, bus.sram_cfg_rd_en, busy);
    end
    n_cmp++;
    if ({bus.sram_cfg_wr_addr, bus.sram_cfg_wr_data, bus.sram_cfg_rd_addr, bus.resp_data} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got wa=%h wd=%h ra=%h rdat=%h, expected 0",
               bus.sram_cfg_wr_addr, bus.sram_cfg_wr_data, bus.sram_cfg_rd_addr, bus.resp_data);
    end
    n_cmp++;
    if ({bus.resp_err, stray_rd_err} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags: got err=%b stray=%b, expected 0 0", bus.resp_err, stray_rd_err);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    wr_exp_t e;
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req_wr[0] = 1'b1;
    bus.req_addr[0 +: AW]  = 22'h001004;
    bus.req_wdata[0 +: DW] = 32'hDEADBEEF;
    wq.push_back('{addr: 22'h001004, data: 32'hDEADBEEF});
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL wr_ready: got %b, expected 01", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    e = wq.pop_front();
    n_cmp++;
    if ({bus.sram_cfg_wr_en, bus.sram_cfg_rd_en, bus.req_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL wr_pulse: got wr=%b rd=%b ready=%b, expected 1 0 00",
               bus.sram_cfg_wr_en, bus.sram_cfg_rd_en, bus.req_ready);
    end
    n_cmp++;
    if (bus.sram_cfg_wr_addr !== e.addr || bus.sram_cfg_wr_data !== e.data) begin
      n_err++;
      $display("FAIL wr_addr_data: got %h/%h, expected %h/%h",
               bus.sram_cfg_wr_addr, bus.sram_cfg_wr_data, e.addr, e.data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({busy, bus.sram_cfg_wr_en, bus.resp_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL wr_done: got busy=%b wr=%b resp=%b, expected 0 0 00",
               busy, bus.sram_cfg_wr_en, bus.resp_valid);
    end
  endtask

  task automatic test_single_read();
    resp_exp_t e;
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    bus.req_wr[1] = 1'b0;
    bus.req_addr[AW +: AW] = 22'h040010;
    rq.push_back('{owner: 1, data: 32'h12345678, err: 1'b0});
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL rd_ready: got %b, expected 10", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.sram_cfg_rd_en !== 1'b1 || bus.sram_cfg_wr_en !== 1'b0 || bus.sram_cfg_rd_addr !== 22'h040010) begin
      n_err++;
      $display("FAIL rd_pulse: got rd=%b wr=%b addr=%h, expected 1 0 040010",
               bus.sram_cfg_rd_en, bus.sram_cfg_wr_en, bus.sram_cfg_rd_addr);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        bus.sram_cfg_rd_data_valid = 1'b1;
        bus.sram_cfg_rd_data       = 32'h12345678;
      end
      @(negedge clk);
      n_cmp++;
      if (bus.resp_valid !== 2'b00) begin
        n_err++;
        $display("FAIL rd_early_resp: got %b at cycle %0d, expected 00", bus.resp_valid, k);
      end
    end
    @(posedge clk); #1;
    bus.sram_cfg_rd_data_valid = 1'b0;
    bus.sram_cfg_rd_data       = '0;
    @(negedge clk);
    e = rq.pop_front();
    n_cmp++;
    if (bus.resp_valid !== (NR'(1) << e.owner) || bus.resp_data !== e.data || bus.resp_err !== e.err) begin
      n_err++;
      $display("FAIL rd_resp: got v=%b d=%h e=%b, expected v=%b d=%h e=%b",
               bus.resp_valid, bus.resp_data, bus.resp_err, NR'(1) << e.owner, e.data, e.err);
    end
  endtask

  task automatic test_fairness();
    wr_exp_t e;
    int      exp_g = 0;
    bus.req_wr = 2'b11;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i*AW +: AW]  = 22'h100000 + AW'(i * 256);
      bus.req_wdata[i*DW +: DW] = 32'hF0000000 + DW'(i * 256);
    end
    bus.req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== (NR'(1) << exp_g)) begin
        n_err++;
        $display("FAIL fair_grant%0d: got %b, expected %b", n, bus.req_ready, NR'(1) << exp_g);
      end
      wq.push_back('{addr: bus.req_addr[exp_g*AW +: AW], data: bus.req_wdata[exp_g*DW +: DW]});
      @(posedge clk); #1;
      bus.req_addr[exp_g*AW +: AW]  = bus.req_addr[exp_g*AW +: AW] + 22'h1;
      bus.req_wdata[exp_g*DW +: DW] = bus.req_wdata[exp_g*DW +: DW] + 32'h11;
      @(negedge clk);
      e = wq.pop_front();
      n_cmp++;
      if (bus.sram_cfg_wr_en !== 1'b1 || bus.req_ready !== 2'b00 ||
          bus.sram_cfg_wr_addr !== e.addr || bus.sram_cfg_wr_data !== e.data) begin
        n_err++;
        $display("FAIL fair_write%0d: got wr=%b rdy=%b %h/%h, expected 1 00 %h/%h", n,
                 bus.sram_cfg_wr_en, bus.req_ready, bus.sram_cfg_wr_addr, bus.sram_cfg_wr_data,
                 e.addr, e.data);
      end
      exp_g = (exp_g + 1) % NR;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.req_wr    = '0;
  endtask

  // Issues a read from requester r and returns once the rd_en cycle has been checked
  task automatic issue_read(input int r, input logic [AW-1:0] addr, input string tag);
    @(posedge clk); #1;
    bus.req_valid = NR'(1) << r;
    bus.req_wr[r] = 1'b0;
    bus.req_addr[r*AW +: AW] = addr;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== (NR'(1) << r)) begin
      n_err++;
      $display("FAIL %s_ready: got %b, expected %b", tag, bus.req_ready, NR'(1) << r);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.sram_cfg_rd_en !== 1'b1 || bus.sram_cfg_rd_addr !== addr) begin
      n_err++;
      $display("FAIL %s_rd_pulse: got rd=%b addr=%h, expected 1 %h", tag,
               bus.sram_cfg_rd_en, bus.sram_cfg_rd_addr, addr);
    end
  endtask

  task automatic test_timeout();
    resp_exp_t e;
    int        early = 0;
    rq.push_back('{owner: 0, data: 32'h0, err: 1'b1});
    issue_read(0, 22'h000ABC, "to");
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.resp_valid !== 2'b00) early++;
    end
    n_cmp++;
    if (early !== 0) begin
      n_err++;
      $display("FAIL to_early_resp: got %0d early pulses, expected 0", early);
    end
    @(posedge clk); #1;
    @(negedge clk);
    e = rq.pop_front();
    n_cmp++;
    if (bus.resp_valid !== (NR'(1) << e.owner) || bus.resp_data !== e.data ||
        bus.resp_err !== e.err || stray_rd_err !== 1'b0) begin
      n_err++;
      $display("FAIL to_resp: got v=%b d=%h e=%b stray=%b, expected v=%b d=%h e=%b stray=0",
               bus.resp_valid, bus.resp_data, bus.resp_err, stray_rd_err,
               NR'(1) << e.owner, e.data, e.err);
    end
    @(posedge clk); #1;
    bus.sram_cfg_rd_data_valid = 1'b1;
    bus.sram_cfg_rd_data       = 32'hFFFF0000;
    @(posedge clk); #1;
    bus.sram_cfg_rd_data_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stray_rd_err !== 1'b1 || bus.resp_valid !== 2'b00 ||
        bus.resp_data !== 32'h0 || bus.resp_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_stray: got stray=%b v=%b d=%h e=%b, expected 1 00 00000000 1",
               stray_rd_err, bus.resp_valid, bus.resp_data, bus.resp_err);
    end
  endtask

  task automatic test_boundary();
    resp_exp_t e;
    rq.push_back('{owner: 1, data: 32'hA5A55A5A, err: 1'b0});
    issue_read(1, 22'h2AAAAA, "bnd");
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      if (k == TO) begin
        bus.sram_cfg_rd_data_valid = 1'b1;
        bus.sram_cfg_rd_data       = 32'hA5A55A5A;
      end
    end
    @(posedge clk); #1;
    bus.sram_cfg_rd_data_valid = 1'b0;
    bus.sram_cfg_rd_data       = '0;
    @(negedge clk);
    e = rq.pop_front();
    n_cmp++;
    if (bus.resp_valid !== (NR'(1) << e.owner) || bus.resp_data !== e.data || bus.resp_err !== e.err) begin
      n_err++;
      $display("FAIL bnd_resp: got v=%b d=%h e=%b, expected v=%b d=%h e=%b",
               bus.resp_valid, bus.resp_data, bus.resp_err, NR'(1) << e.owner, e.data, e.err);
    end
  endtask

  task automatic test_reset_mid_read();
    resp_exp_t e;
    int        spurious = 0;
    issue_read(0, 22'h3FFFFF, "rst");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, bus.sram_cfg_rd_en, bus.sram_cfg_wr_en, bus.resp_valid, bus.resp_err, stray_rd_err} !== '0 ||
        {bus.resp_data, bus.sram_cfg_wr_addr, bus.sram_cfg_wr_data, bus.sram_cfg_rd_addr} !== '0) begin
      n_err++;
      $display("FAIL rst_async: got busy=%b rd=%b v=%b d=%h e=%b stray=%b wa=%h ra=%h, expected all 0",
               busy, bus.sram_cfg_rd_en, bus.resp_valid, bus.resp_data, bus.resp_err,
               stray_rd_err, bus.sram_cfg_wr_addr, bus.sram_cfg_rd_addr);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.resp_valid !== 2'b00 || busy !== 1'b0) spurious++;
    end
    n_cmp++;
    if (spurious !== 0) begin
      n_err++;
      $display("FAIL rst_no_resp: got %0d active cycles, expected 0", spurious);
    end
    // Both requesting: a reset pointer must favour requester 0
    rq.push_back('{owner: 0, data: 32'h0BADF00D, err: 1'b0});
    @(posedge clk); #1;
    bus.req_wr    = 2'b00;
    bus.req_addr  = {22'h111111, 22'h000123};
    bus.req_valid = 2'b11;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL rst_ptr: got %b, expected 01", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.sram_cfg_rd_en !== 1'b1 || bus.sram_cfg_rd_addr !== 22'h000123) begin
      n_err++;
      $display("FAIL rst_rd_pulse: got rd=%b addr=%h, expected 1 000123",
               bus.sram_cfg_rd_en, bus.sram_cfg_rd_addr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sram_cfg_rd_data_valid = 1'b1;
    bus.sram_cfg_rd_data       = 32'h0BADF00D;
    @(posedge clk); #1;
    bus.sram_cfg_rd_data_valid = 1'b0;
    @(negedge clk);
    e = rq.pop_front();
    n_cmp++;
    if (bus.resp_valid !== (NR'(1) << e.owner) || bus.resp_data !== e.data ||
        bus.resp_err !== e.err || stray_rd_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_new_read: got v=%b d=%h e=%b stray=%b, expected v=%b d=%h e=%b stray=0",
               bus.resp_valid, bus.resp_data, bus.resp_err, stray_rd_err,
               NR'(1) << e.owner, e.data, e.err);
    end
  endtask

  initial begin
    reset_n                    = 1'b0;
    bus.req_valid              = '0;
    bus.req_wr                 = '0;
    bus.req_addr               = '0;
    bus.req_wdata              = '0;
    bus.sram_cfg_rd_data       = '0;
    bus.sram_cfg_rd_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_write();
    test_single_read();
    test_fairness();
    test_timeout();
    test_boundary();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule : tb_glb_sram_cfg_arbiter
`default_nettype wire
